// File: rtl/eightxthree_encoder.sv
`default_nettype none
// ============================================================================
// Module      : eightxthree_encoder
// Description : Sequential 8-to-3 request encoder. Eight request lines are
//               captured into a pending register, and one 3-bit index at a
//               time is presented over a valid/ready handshake.
//               Simultaneous requests are serialized and never lost.
//               Optional macro ENC_ROUND_ROBIN_EN selects round-robin
//               arbitration. The default build uses fixed lowest-index
//               priority.
// Revision    : 1.0 - initial release
// ============================================================================
module eightxthree_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] code,
    output logic [7:0] pending,
    output logic       busy
);

    logic [7:0] r_pending;
    logic       r_valid;
    logic [2:0] r_code;

    logic [2:0] w_sel;
    logic       w_load;
    logic [7:0] w_load_mask;

    // The slot takes a new index whenever it is empty or being drained
    // this edge, and something is waiting.
    assign w_load      = (!r_valid || out_ready) && (r_pending != 8'h00);
    assign w_load_mask = w_load ? (8'd1 << w_sel) : 8'd0;

`ifdef ENC_ROUND_ROBIN_EN
    logic [2:0] r_ptr;
    logic [2:0] w_start;
    logic [2:0] w_idx;
    logic [7:0] w_rot;
    logic [2:0] w_off;

    // The search begins one past the last served index.
    assign w_start = r_ptr + 3'd1;

    // Rotate pending so that bit 0 of w_rot is the first candidate.
    always_comb begin
        w_rot = 8'h00;
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_idx    = w_start + 3'(i);
            w_rot[i] = r_pending[w_idx];
        end
    end

    // Pick the lowest set bit of the rotated view, then map it back to an
    // absolute index.
    always_comb begin
        w_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 3'(i);
            end
        end
        w_sel = w_start + w_off;
    end

    // Remember the last loaded index. Reset to 7 gives index 0 first turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 3'd7;
        end else if (w_load) begin
            r_ptr <= w_sel;
        end
    end
`else
    // Fixed priority: the lowest pending index wins.
    always_comb begin
        w_sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = 3'(i);
            end
        end
    end
`endif

    // Pending capture and output slot. A req on the bit being loaded
    // re-arms that bit, so the new event is served again later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 8'h00;
            r_valid   <= 1'b0;
            r_code    <= 3'd0;
        end else begin
            r_pending <= (r_pending & ~w_load_mask) | req;
            if (w_load) begin
                r_valid <= 1'b1;
                r_code  <= w_sel;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign code      = r_code;
    assign pending   = r_pending;
    assign busy      = (|r_pending) | r_valid;

endmodule
`default_nettype wire

// File: tb/tb_eightxthree_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_eightxthree_encoder
// Description : Scoreboard testbench for eightxthree_encoder. The stimulus
//               process queues expected codes, and a monitor checks every
//               accepted handshake against that queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eightxthree_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] code;
    logic [7:0] pending;
    logic       busy;

    int         n_checks;
    int         n_fail;
    logic [2:0] exp_q[$];

    logic       held_v;
    logic [2:0] held_code;
    logic [2:0] exp_code;

    eightxthree_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code      (code),
        .pending   (pending),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: checks that a stalled code stays stable, and checks each
    // accepted code against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                n_checks++;
                if (out_valid !== 1'b1 || code !== held_code) begin
                    n_fail++;
                    $display("FAIL hold_stable: got valid=%0b code=%0d expected valid=1 code=%0d",
                             out_valid, code, held_code);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got code=%0d expected no output", code);
                end else begin
                    exp_code = exp_q.pop_front();
                    if (code !== exp_code) begin
                        n_fail++;
                        $display("FAIL code: got %0d expected %0d", code, exp_code);
                    end
                end
            end
            held_v    = (out_valid === 1'b1) && (out_ready === 1'b0);
            held_code = code;
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        held_v    = 1'b0;
        held_code = 3'd0;
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        chk("rst_valid",   {7'd0, out_valid}, 8'h00);
        chk("rst_code",    {5'd0, code},      8'h00);
        chk("rst_pending", pending,           8'h00);
        chk("rst_busy",    {7'd0, busy},      8'h00);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-cycle with the slot and pending both full
        out_ready = 1'b0;
        req       = 8'hFF;
        tick();
        tick();
        chk("pre_rst_pending", pending,           8'hFF);
        chk("pre_rst_valid",   {7'd0, out_valid}, 8'h01);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",   {7'd0, out_valid}, 8'h00);
        chk("arst_code",    {5'd0, code},      8'h00);
        chk("arst_pending", pending,           8'h00);
        chk("arst_busy",    {7'd0, busy},      8'h00);
        tick();
        req       = 8'h00;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        tick();

        // Single event: visible two edges after sampling, lasts one cycle
        req = 8'b0010_0000;
        exp_q.push_back(3'd5);
        tick();
        req = 8'h00;
        chk("se_pending", pending,           8'h20);
        chk("se_valid0",  {7'd0, out_valid}, 8'h00);
        tick();
        chk("se_valid1",  {7'd0, out_valid}, 8'h01);
        chk("se_code",    {5'd0, code},      8'h05);
        chk("se_pend0",   pending,           8'h00);
        tick();
        chk("se_valid2",  {7'd0, out_valid}, 8'h00);
        chk("se_busy",    {7'd0, busy},      8'h00);

        // Backpressure
        out_ready = 1'b0;
        req       = 8'h81;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd7);
        tick();
        req = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",   {7'd0, out_valid}, 8'h01);
            chk("bp_code",    {5'd0, code},      8'h00);
            chk("bp_pending", pending,           8'h80);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_code7",   {5'd0, code},      8'h07);
        chk("bp_valid7",  {7'd0, out_valid}, 8'h01);
        tick();
        chk("bp_empty",   {7'd0, out_valid}, 8'h00);

        // Re-request of the index held in the slot
        out_ready = 1'b0;
        req       = 8'h08;
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd3);
        tick();
        req = 8'h00;
        tick();
        chk("rr_code",    {5'd0, code}, 8'h03);
        req = 8'h08;
        tick();
        req = 8'h00;
        chk("rr_pending", pending,      8'h08);
        tick();
        chk("rr_held",    {5'd0, code}, 8'h03);
        out_ready = 1'b1;
        tick();
        chk("rr_valid2",  {7'd0, out_valid}, 8'h01);
        chk("rr_code2",   {5'd0, code},      8'h03);
        chk("rr_pend2",   pending,           8'h00);
        tick();
        chk("rr_empty",   {7'd0, out_valid}, 8'h00);

        // Priority: req 0101 held for six edges
`ifdef ENC_ROUND_ROBIN_EN
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 3'd0 : 3'd2);
        exp_q.push_back(3'd0);
`else
        for (int i = 0; i < 6; i++) exp_q.push_back(3'd0);
        exp_q.push_back(3'd2);
`endif
        req = 8'b0000_0101;
        repeat (6) tick();
        req = 8'h00;
        repeat (5) tick();
        chk("pri_idle", {7'd0, busy}, 8'h00);

        // Burst from reset: 8 consecutive codes, ascending
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req = 8'hFF;
        for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
        tick();
        req = 8'h00;
        chk("bu_valid0", {7'd0, out_valid}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bu_valid", {7'd0, out_valid}, 8'h01);
            chk("bu_busy",  {7'd0, busy},      8'h01);
        end
        tick();
        chk("bu_valid_end", {7'd0, out_valid}, 8'h00);
        chk("bu_busy_end",  {7'd0, busy},      8'h00);

        tick();
        chk("sb_drained", 8'(exp_q.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
